// File: rtl/rx4p_mc_receiver_pkg.sv
// Shared defaults, channel FSM encoding and helpers for the multi-channel 4-phase receiver.
package rx4p_mc_receiver_pkg;

  localparam int unsigned DefNch        = 4;
  localparam int unsigned DefDw         = 8;
  localparam int unsigned DefSyncStages = 2;

  // Per-channel handshake state: IDLE waits for a request, ACKH holds ack until req drops.
  typedef enum logic {
    StIdle = 1'b0,
    StAckh = 1'b1
  } chan_state_e;

  // Channel tag width; a single channel still needs a 1-bit tag.
  function automatic int unsigned chan_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx4p_mc_receiver_chan.sv
// One receive channel: req synchroniser, 4-phase handshake FSM and a one-word hold register.
module rx4p_mc_receiver_chan
  import rx4p_mc_receiver_pkg::*;
#(
  parameter int unsigned DW          = DefDw,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic          clk_rx,
  input  logic          reset,
  input  logic          req,
  input  logic [DW-1:0] data,
  input  logic          drain,
  output logic          ack,
  output logic [DW-1:0] hold,
  output logic          full
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   reqs;
  chan_state_e            state_q, state_d;
  logic                   capture;
  logic [DW-1:0]          hold_q;
  logic                   full_q;

  // Synchroniser chain; only its last stage is looked at by the FSM.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end
  end

  assign reqs = sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; capture only into an empty hold (registered flag, no same-cycle bypass).
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (reqs && !full_q) begin
          state_d = StAckh;
          capture = 1'b1;
        end
      end
      StAckh: begin
        if (!reqs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ack is decoded straight from the state flop, so it is glitch-free toward the sender.
  always_comb begin
    ack = (state_q == StAckh);
  end

  // Hold register; capture and drain never coincide because capture needs an empty hold.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (capture) begin
      hold_q <= data;
      full_q <= 1'b1;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  assign hold = hold_q;
  assign full = full_q;

endmodule

// File: rtl/rx4p_mc_receiver.sv
// Multi-channel 4-phase receiver: NCH handshake channels merged round-robin onto one
// registered valid/ready stream tagged with the source channel.
module rx4p_mc_receiver
  import rx4p_mc_receiver_pkg::*;
#(
  parameter int unsigned NCH         = DefNch,
  parameter int unsigned DW          = DefDw,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  localparam int unsigned CHW        = chan_width(NCH)
) (
  input  logic              clk_rx,
  input  logic              reset,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] data,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic [CHW-1:0]    rch,
  output logic              vo,
  input  logic              rdy
);

  logic [NCH-1:0] full;
  logic [NCH-1:0] drain;
  logic [DW-1:0]  hold [NCH];

  logic           found;
  logic [CHW-1:0] sel;
  logic [CHW-1:0] ptr_next;
  logic [DW-1:0]  sel_data;
  logic           load;

  logic [CHW-1:0] ptr_q;
  logic [DW-1:0]  rdata_q;
  logic [CHW-1:0] rch_q;
  logic           vo_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    rx4p_mc_receiver_chan #(
      .DW          (DW),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk_rx (clk_rx),
      .reset  (reset),
      .req    (req[i]),
      .data   (data[i*DW +: DW]),
      .drain  (drain[i]),
      .ack    (ack[i]),
      .hold   (hold[i]),
      .full   (full[i])
    );
  end

  // Round-robin pick: first full channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!found && full[i] && (((32'(ptr_q) + k) % NCH) == i)) begin
          found    = 1'b1;
          sel      = CHW'(i);
          sel_data = hold[i];
        end
      end
    end
    ptr_next = (32'(sel) == NCH - 1) ? '0 : sel + 1'b1;
  end

  // The output register takes a word when it is empty or being accepted this cycle.
  always_comb begin
    load  = found && (!vo_q || rdy);
    drain = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      drain[i] = load && (32'(sel) == i);
    end
  end

  // Output register and arbitration pointer; data and tag keep their value after drain.
  always_ff @(posedge clk_rx) begin
    if (reset) begin
      rdata_q <= '0;
      rch_q   <= '0;
      vo_q    <= 1'b0;
      ptr_q   <= '0;
    end else if (load) begin
      rdata_q <= sel_data;
      rch_q   <= sel;
      vo_q    <= 1'b1;
      ptr_q   <= ptr_next;
    end else if (vo_q && rdy) begin
      vo_q    <= 1'b0;
    end
  end

  assign rdata = rdata_q;
  assign rch   = rch_q;
  assign vo    = vo_q;

endmodule

// File: tb/tb_rx4p_mc_receiver.sv
// Bench for rx4p_mc_receiver: directed latency/backpressure/fairness/reset cases plus
// randomized multi-sender traffic, checked by a per-channel scoreboard.
module tb_rx4p_mc_receiver;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] data;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic [CHW-1:0]    rch;
  logic              vo;
  logic              rdy;

  // Second instance: one wide channel with a deeper synchroniser.
  logic        req1;
  logic [31:0] data1;
  logic        ack1;
  logic [31:0] rdata1;
  logic [0:0]  rch1;
  logic        vo1;
  logic        rdy1;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  // Expected words per channel, pushed when a sender issues them.
  logic [DW-1:0] exp_q [NCH][$];

  always #5 clk = ~clk;

  rx4p_mc_receiver #(
    .NCH         (NCH),
    .DW          (DW),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk_rx (clk),
    .reset  (reset),
    .req    (req),
    .data   (data),
    .ack    (ack),
    .rdata  (rdata),
    .rch    (rch),
    .vo     (vo),
    .rdy    (rdy)
  );

  rx4p_mc_receiver #(
    .NCH         (1),
    .DW          (32),
    .SYNC_STAGES (3)
  ) u_dut1 (
    .clk_rx (clk),
    .reset  (reset),
    .req    (req1),
    .data   (data1),
    .ack    (ack1),
    .rdata  (rdata1),
    .rch    (rch1),
    .vo     (vo1),
    .rdy    (rdy1)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int ch, logic [DW-1:0] d);
    data[ch*DW +: DW] = d;
    req[ch]           = 1'b1;
    exp_q[ch].push_back(d);
  endtask

  task automatic wait_ack(int ch, logic lvl, int budget, string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      tick();
      if (ack[ch] === lvl) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s ch%0d: ack=%b after %0d cycles, required %b", nm, ch, ack[ch], budget,
               lvl);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    req1  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic sender(int ch, int n);
    for (int j = 0; j < n; j++) begin
      repeat ($urandom_range(0, 4)) tick();
      issue(ch, DW'($urandom));
      wait_ack(ch, 1'b1, 400, "rand_ack_rise");
      req[ch] = 1'b0;
      wait_ack(ch, 1'b0, 400, "rand_ack_fall");
    end
    done_cnt++;
  endtask

  // Monitor: at the falling edge, inputs and outputs describe the coming transfer edge.
  initial begin
    logic          stall = 1'b0;
    logic [DW-1:0] pd    = '0;
    logic [CHW-1:0] pc   = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_hold", {23'd0, vo, rch, rdata}, {23'd0, 1'b1, pc, pd});
        if (vo && rdy) begin
          if (exp_q[rch].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: ch%0d data 0x%0h, required no word", rch, rdata);
          end else begin
            e = exp_q[rch].pop_front();
            chk($sformatf("word_ch%0d", rch), 32'(rdata), 32'(e));
          end
        end
        stall = vo && !rdy;
        pd    = rdata;
        pc    = rch;
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    data  = '0;
    rdy   = 1'b0;
    req1  = 1'b0;
    data1 = '0;
    rdy1  = 1'b1;
    do_reset();

    // Reset state.
    chk("rst_ack", 32'(ack), 0);
    chk("rst_vo", 32'(vo), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rch", 32'(rch), 0);
    chk("rst_vo1", 32'(vo1), 0);

    // Single transfer on channel 2.
    rdy = 1'b1;
    issue(2, 8'hA5);
    tick();
    tick();
    chk("single_ack_e2", 32'(ack[2]), 0);
    tick();
    chk("single_ack_e3", 32'(ack[2]), 1);
    chk("single_vo_e3", 32'(vo), 0);
    tick();
    chk("single_out_e4", {21'd0, vo, rch, rdata}, {21'd0, 1'b1, 2'd2, 8'hA5});
    tick();
    chk("single_vo_e5", 32'(vo), 0);
    req[2] = 1'b0;
    tick();
    tick();
    chk("single_rel_e2", 32'(ack[2]), 1);
    tick();
    chk("single_rel_e3", 32'(ack[2]), 0);

    // Wide / deep-sync instance.
    do_reset();
    data1 = 32'hDEADBEEF;
    req1  = 1'b1;
    repeat (3) tick();
    chk("sweep_ack_e3", 32'(ack1), 0);
    tick();
    chk("sweep_ack_e4", 32'(ack1), 1);
    chk("sweep_vo_e4", 32'(vo1), 0);
    tick();
    chk("sweep_vo_e5", 32'(vo1), 1);
    chk("sweep_rdata", rdata1, 32'hDEADBEEF);
    chk("sweep_rch", 32'(rch1), 0);
    tick();
    chk("sweep_vo_e6", 32'(vo1), 0);
    req1 = 1'b0;
    repeat (3) tick();
    chk("sweep_rel_e3", 32'(ack1), 1);
    tick();
    chk("sweep_rel_e4", 32'(ack1), 0);

    // Backpressure on channel 0.
    do_reset();
    rdy = 1'b0;
    issue(0, 8'h11);
    wait_ack(0, 1'b1, 10, "bp_ack1");
    req[0] = 1'b0;
    wait_ack(0, 1'b0, 10, "bp_rel1");
    issue(0, 8'h22);
    wait_ack(0, 1'b1, 10, "bp_ack2");
    req[0] = 1'b0;
    wait_ack(0, 1'b0, 10, "bp_rel2");
    issue(0, 8'h33);
    repeat (10) tick();
    chk("bp_ack_withheld", 32'(ack[0]), 0);
    chk("bp_out_held", {21'd0, vo, rch, rdata}, {21'd0, 1'b1, 2'd0, 8'h11});
    rdy = 1'b1;
    tick();
    chk("bp_next_word", {21'd0, vo, rch, rdata}, {21'd0, 1'b1, 2'd0, 8'h22});
    wait_ack(0, 1'b1, 10, "bp_ack3");
    req[0] = 1'b0;
    wait_ack(0, 1'b0, 10, "bp_rel3");
    repeat (4) tick();

    // Fairness: all channels at once from pointer 0.
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c < NCH; c++) issue(c, 8'(8'h10 + c));
    repeat (3) tick();
    for (int k = 0; k < NCH; k++) begin
      tick();
      chk($sformatf("rr_slot%0d", k), {21'd0, vo, rch, rdata},
          {21'd0, 1'b1, 2'(k), 8'(8'h10 + k)});
    end
    req = '0;
    for (int c = 0; c < NCH; c++) wait_ack(c, 1'b0, 10, "rr_rel");
    repeat (3) tick();

    // Reset in the middle of a handshake with an unaccepted output word.
    do_reset();
    rdy = 1'b0;
    issue(1, 8'h5C);
    wait_ack(1, 1'b1, 10, "mid_ack");
    tick();
    chk("mid_vo_before", 32'(vo), 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_vo", 32'(vo), 0);
    reset = 1'b0;
    tick();
    tick();
    chk("mid_reack_e2", 32'(ack[1]), 0);
    tick();
    chk("mid_reack_e3", 32'(ack[1]), 1);
    rdy    = 1'b1;
    req[1] = 1'b0;
    wait_ack(1, 1'b0, 10, "mid_rel");
    repeat (5) tick();

    // Idle stability.
    do_reset();
    rdy = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick();
      chk("idle_outputs", {17'd0, ack, vo, rch, rdata}, 32'd0);
    end

    // Randomized traffic from all senders with random downstream stalls.
    do_reset();
    done_cnt = 0;
    fork
      begin
        while (done_cnt < NCH) begin
          tick();
          rdy = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int c = 0; c < NCH; c++) begin
      automatic int ch = c;
      fork
        sender(ch, 20);
      join_none
    end
    wait fork;
    rdy = 1'b1;
    repeat (20) tick();

    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("queue_empty_ch%0d", c), 32'(exp_q[c].size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
